// File: rtl/anabellek_hakemi_pkg.sv
// Shared types and constants for the instruction/data cache memory arbiter.
// Optional starvation guard is selected with the ACLIK_SAYACI_EN macro.
package anabellek_hakemi_pkg;

  localparam int BLOK_W  = 128;
  localparam int OFSET_W = 4;
  localparam int ADRES_W = 32;

  typedef enum logic [1:0] {
    BOSTA        = 2'd0,
    VERI_ISLEM   = 2'd1,
    BUYRUK_ISLEM = 2'd2
  } durum_e;

  // Clears the byte offset inside a cache block so the burst starts block-aligned.
  function automatic logic [ADRES_W-1:0] blok_hizala(input logic [ADRES_W-1:0] adres);
    return adres & {{(ADRES_W-OFSET_W){1'b1}}, {OFSET_W{1'b0}}};
  endfunction

endpackage

// File: rtl/anabellek_hakemi_aclik_sayaci.sv
// Starvation counter: counts data grants made while an instruction request waits.
// Only instantiated when ACLIK_SAYACI_EN is defined.
module aclik_sayaci #(
  parameter int ACLIK_ESIK = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic bb_istek,
  input  logic veri_kabul,
  input  logic buyruk_kabul,
  output logic esik_doldu
);

  localparam int SAYAC_W = $clog2(ACLIK_ESIK + 1);
  localparam logic [SAYAC_W-1:0] ESIK_DEGER = SAYAC_W'(ACLIK_ESIK);
  localparam logic [SAYAC_W-1:0] BIR        = SAYAC_W'(1);

  logic [SAYAC_W-1:0] sayac_r;

  // Saturating count of consecutive data grants while the instruction side is waiting
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sayac_r <= {SAYAC_W{1'b0}};
    end else if (!bb_istek || buyruk_kabul) begin
      sayac_r <= {SAYAC_W{1'b0}};
    end else if (veri_kabul && (sayac_r != ESIK_DEGER)) begin
      sayac_r <= sayac_r + BIR;
    end else begin
      sayac_r <= sayac_r;
    end
  end

  assign esik_doldu = (sayac_r == ESIK_DEGER);

endmodule

// File: rtl/anabellek_hakemi.sv
// Arbiter sharing one burst engine between the instruction and data caches.
// Define ACLIK_SAYACI_EN to compile in the instruction starvation guard (ACLIK_ESIK).
module anabellek_hakemi
  import anabellek_hakemi_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               bb_istek_i,
  input  logic [ADRES_W-1:0] bb_adres_i,
  output logic               bb_kabul_o,
  output logic               bb_hazir_o,
  output logic [BLOK_W-1:0]  bb_veri_o,
  input  logic               vb_istek_i,
  input  logic               vb_yaz_i,
  input  logic [ADRES_W-1:0] vb_adres_i,
  input  logic [BLOK_W-1:0]  vb_veri_i,
  output logic               vb_kabul_o,
  output logic               vb_hazir_o,
  output logic [BLOK_W-1:0]  vb_veri_o,
  output logic               ab_istek_o,
  output logic               ab_yaz_o,
  output logic [ADRES_W-1:0] ab_adres_o,
  output logic [BLOK_W-1:0]  ab_veri_o,
  input  logic               ab_musait_i,
  input  logic               ab_bitti_i,
  input  logic [BLOK_W-1:0]  ab_veri_i
);

`ifdef ACLIK_SAYACI_EN
  parameter int ACLIK_ESIK = 4;
`endif

  durum_e durum_r;
  durum_e durum_next_s;
  logic   veri_kabul_s;
  logic   buyruk_kabul_s;
  logic   veri_bitti_s;
  logic   buyruk_bitti_s;
  logic   buyruk_oncelik_s;

`ifdef ACLIK_SAYACI_EN
  aclik_sayaci #(
    .ACLIK_ESIK (ACLIK_ESIK)
  ) u_aclik_sayaci (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .bb_istek     (bb_istek_i),
    .veri_kabul   (veri_kabul_s),
    .buyruk_kabul (buyruk_kabul_s),
    .esik_doldu   (buyruk_oncelik_s)
  );
`else
  assign buyruk_oncelik_s = 1'b0;
`endif

  // Grant selection and burst completion decode
  always_comb begin
    durum_next_s   = durum_r;
    veri_kabul_s   = 1'b0;
    buyruk_kabul_s = 1'b0;
    veri_bitti_s   = 1'b0;
    buyruk_bitti_s = 1'b0;
    case (durum_r)
      BOSTA: begin
        // Data wins unless the starvation guard hands this slot to the instruction side
        if (ab_musait_i && vb_istek_i && !(bb_istek_i && buyruk_oncelik_s)) begin
          veri_kabul_s = 1'b1;
          durum_next_s = VERI_ISLEM;
        end else if (ab_musait_i && bb_istek_i) begin
          buyruk_kabul_s = 1'b1;
          durum_next_s   = BUYRUK_ISLEM;
        end else begin
          durum_next_s = BOSTA;
        end
      end
      VERI_ISLEM: begin
        if (ab_bitti_i) begin
          veri_bitti_s = 1'b1;
          durum_next_s = BOSTA;
        end else begin
          durum_next_s = VERI_ISLEM;
        end
      end
      BUYRUK_ISLEM: begin
        if (ab_bitti_i) begin
          buyruk_bitti_s = 1'b1;
          durum_next_s   = BOSTA;
        end else begin
          durum_next_s = BUYRUK_ISLEM;
        end
      end
      default: begin
        durum_next_s = BOSTA;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      durum_r <= BOSTA;
    end else begin
      durum_r <= durum_next_s;
    end
  end

  // Registered handshakes; burst request fields hold from grant until the next grant
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bb_kabul_o <= 1'b0;
      vb_kabul_o <= 1'b0;
      ab_istek_o <= 1'b0;
      bb_hazir_o <= 1'b0;
      vb_hazir_o <= 1'b0;
      ab_yaz_o   <= 1'b0;
      ab_adres_o <= {ADRES_W{1'b0}};
      ab_veri_o  <= {BLOK_W{1'b0}};
      bb_veri_o  <= {BLOK_W{1'b0}};
      vb_veri_o  <= {BLOK_W{1'b0}};
    end else begin
      bb_kabul_o <= buyruk_kabul_s;
      vb_kabul_o <= veri_kabul_s;
      ab_istek_o <= veri_kabul_s | buyruk_kabul_s;
      bb_hazir_o <= buyruk_bitti_s;
      vb_hazir_o <= veri_bitti_s;
      if (veri_kabul_s) begin
        ab_adres_o <= blok_hizala(vb_adres_i);
        ab_yaz_o   <= vb_yaz_i;
        ab_veri_o  <= vb_veri_i;
      end else if (buyruk_kabul_s) begin
        ab_adres_o <= blok_hizala(bb_adres_i);
        ab_yaz_o   <= 1'b0;
      end
      // ab_yaz_o still holds the flag of the burst that is finishing
      if (veri_bitti_s && !ab_yaz_o) begin
        vb_veri_o <= ab_veri_i;
      end
      if (buyruk_bitti_s) begin
        bb_veri_o <= ab_veri_i;
      end
    end
  end

endmodule

// File: tb/tb_anabellek_hakemi.sv
// Self-checking bench for anabellek_hakemi: directed vector table, fairness sequence,
// and randomized traffic against a transaction-level reference model.
module tb_anabellek_hakemi;

`ifdef ACLIK_SAYACI_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif
  localparam int ESIK = 4;

  localparam logic [127:0] Z   = 128'h0;
  localparam logic [127:0] A5  = {16{8'hA5}};
  localparam logic [127:0] C3  = {16{8'hC3}};
  localparam logic [127:0] P11 = {8{16'h1111}};
  localparam logic [127:0] D   = 128'h0123456789ABCDEF0123456789ABCDEF;
  localparam logic [127:0] EE  = {16{8'hEE}};
  localparam logic [127:0] FF  = {16{8'hFF}};

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         bb_istek_i;
  logic [31:0]  bb_adres_i;
  logic         bb_kabul_o, bb_hazir_o;
  logic [127:0] bb_veri_o;
  logic         vb_istek_i, vb_yaz_i;
  logic [31:0]  vb_adres_i;
  logic [127:0] vb_veri_i;
  logic         vb_kabul_o, vb_hazir_o;
  logic [127:0] vb_veri_o;
  logic         ab_istek_o, ab_yaz_o;
  logic [31:0]  ab_adres_o;
  logic [127:0] ab_veri_o;
  logic         ab_musait_i, ab_bitti_i;
  logic [127:0] ab_veri_i;

  always #5 clk_i = ~clk_i;

  anabellek_hakemi dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .bb_istek_i(bb_istek_i), .bb_adres_i(bb_adres_i),
    .bb_kabul_o(bb_kabul_o), .bb_hazir_o(bb_hazir_o), .bb_veri_o(bb_veri_o),
    .vb_istek_i(vb_istek_i), .vb_yaz_i(vb_yaz_i), .vb_adres_i(vb_adres_i), .vb_veri_i(vb_veri_i),
    .vb_kabul_o(vb_kabul_o), .vb_hazir_o(vb_hazir_o), .vb_veri_o(vb_veri_o),
    .ab_istek_o(ab_istek_o), .ab_yaz_o(ab_yaz_o), .ab_adres_o(ab_adres_o), .ab_veri_o(ab_veri_o),
    .ab_musait_i(ab_musait_i), .ab_bitti_i(ab_bitti_i), .ab_veri_i(ab_veri_i)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic         rst, bb_i;
    logic [31:0]  bb_adr;
    logic         vb_i, vb_yaz;
    logic [31:0]  vb_adr;
    logic [127:0] vb_dat;
    logic         musait, bitti;
    logic [127:0] ab_dat;
    logic         e_bbk, e_vbk, e_ist, e_yaz;
    logic [31:0]  e_adr;
    logic [127:0] e_abdat;
    logic         e_bbh, e_vbh;
    logic [127:0] e_bbdat, e_vbdat;
  } vec_t;

  vec_t vecs[22];

  task automatic reset_dut();
    rst_i = 1'b1; bb_istek_i = 1'b0; bb_adres_i = 32'h0; vb_istek_i = 1'b0; vb_yaz_i = 1'b0;
    vb_adres_i = 32'h0; vb_veri_i = Z; ab_musait_i = 1'b1; ab_bitti_i = 1'b0; ab_veri_i = Z;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
  endtask

  // reference model state for the random phase
  bit           m_busy, m_kind, m_yaz;
  logic [31:0]  m_adr;
  logic [127:0] m_abveri, m_vbveri, m_bbveri;
  int           m_cnt;
  bit           p_vbk, p_bbk, p_vbh, p_bbh;
  bit           bb_act, vb_act, eng_busy;
  int           eng_lat;

  initial begin
    //          rst   bb    bb_adr      vb    yaz   vb_adr      vb_dat mu    bt    ab_dat  bbk   vbk   ist   yaz   adr         abdat bbh   vbh   bbdat vbdat
    vecs[0]  = '{1'b1,1'b0,32'h0,      1'b0,1'b0,32'h0,      Z,  1'b1,1'b0,Z,   1'b0,1'b0,1'b0,1'b0,32'h0,     Z, 1'b0,1'b0,Z,  Z};
    vecs[1]  = '{1'b0,1'b1,32'h1234,   1'b0,1'b0,32'h0,      Z,  1'b1,1'b0,Z,   1'b1,1'b0,1'b1,1'b0,32'h1230,  Z, 1'b0,1'b0,Z,  Z};
    vecs[2]  = '{1'b0,1'b0,32'h0,      1'b0,1'b0,32'h0,      Z,  1'b1,1'b0,Z,   1'b0,1'b0,1'b0,1'b0,32'h1230,  Z, 1'b0,1'b0,Z,  Z};
    vecs[3]  = '{1'b0,1'b0,32'h0,      1'b0,1'b0,32'h0,      Z,  1'b1,1'b1,C3,  1'b0,1'b0,1'b0,1'b0,32'h1230,  Z, 1'b1,1'b0,C3, Z};
    vecs[4]  = '{1'b0,1'b1,32'h2000,   1'b1,1'b0,32'h3008,   Z,  1'b1,1'b0,Z,   1'b0,1'b1,1'b1,1'b0,32'h3000,  Z, 1'b0,1'b0,C3, Z};
    vecs[5]  = '{1'b0,1'b1,32'h2000,   1'b0,1'b0,32'h0,      Z,  1'b1,1'b0,Z,   1'b0,1'b0,1'b0,1'b0,32'h3000,  Z, 1'b0,1'b0,C3, Z};
    vecs[6]  = '{1'b0,1'b1,32'h2000,   1'b0,1'b0,32'h0,      Z,  1'b1,1'b1,A5,  1'b0,1'b0,1'b0,1'b0,32'h3000,  Z, 1'b0,1'b1,C3, A5};
    vecs[7]  = '{1'b0,1'b1,32'h2000,   1'b0,1'b0,32'h0,      Z,  1'b1,1'b0,Z,   1'b1,1'b0,1'b1,1'b0,32'h2000,  Z, 1'b0,1'b0,C3, A5};
    vecs[8]  = '{1'b0,1'b0,32'h0,      1'b0,1'b0,32'h0,      Z,  1'b1,1'b0,Z,   1'b0,1'b0,1'b0,1'b0,32'h2000,  Z, 1'b0,1'b0,C3, A5};
    vecs[9]  = '{1'b0,1'b0,32'h0,      1'b0,1'b0,32'h0,      Z,  1'b1,1'b1,P11, 1'b0,1'b0,1'b0,1'b0,32'h2000,  Z, 1'b1,1'b0,P11,A5};
    vecs[10] = '{1'b0,1'b0,32'h0,      1'b1,1'b1,32'h40F,    D,  1'b0,1'b0,Z,   1'b0,1'b0,1'b0,1'b0,32'h2000,  Z, 1'b0,1'b0,P11,A5};
    vecs[11] = '{1'b0,1'b0,32'h0,      1'b1,1'b1,32'h40F,    D,  1'b0,1'b0,Z,   1'b0,1'b0,1'b0,1'b0,32'h2000,  Z, 1'b0,1'b0,P11,A5};
    vecs[12] = '{1'b0,1'b0,32'h0,      1'b1,1'b1,32'h40F,    D,  1'b1,1'b0,Z,   1'b0,1'b1,1'b1,1'b1,32'h400,   D, 1'b0,1'b0,P11,A5};
    vecs[13] = '{1'b0,1'b0,32'h0,      1'b0,1'b0,32'h0,      FF, 1'b1,1'b0,Z,   1'b0,1'b0,1'b0,1'b1,32'h400,   D, 1'b0,1'b0,P11,A5};
    vecs[14] = '{1'b0,1'b0,32'h0,      1'b0,1'b0,32'h0,      FF, 1'b1,1'b1,EE,  1'b0,1'b0,1'b0,1'b1,32'h400,   D, 1'b0,1'b1,P11,A5};
    vecs[15] = '{1'b0,1'b0,32'h0,      1'b0,1'b0,32'h0,      FF, 1'b1,1'b1,EE,  1'b0,1'b0,1'b0,1'b1,32'h400,   D, 1'b0,1'b0,P11,A5};
    vecs[16] = '{1'b0,1'b0,32'h0,      1'b1,1'b0,32'h500,    Z,  1'b0,1'b0,Z,   1'b0,1'b0,1'b0,1'b1,32'h400,   D, 1'b0,1'b0,P11,A5};
    vecs[17] = '{1'b0,1'b0,32'h0,      1'b0,1'b0,32'h500,    Z,  1'b1,1'b0,Z,   1'b0,1'b0,1'b0,1'b1,32'h400,   D, 1'b0,1'b0,P11,A5};
    vecs[18] = '{1'b0,1'b0,32'h0,      1'b1,1'b0,32'h600,    Z,  1'b1,1'b0,Z,   1'b0,1'b1,1'b1,1'b0,32'h600,   Z, 1'b0,1'b0,P11,A5};
    vecs[19] = '{1'b1,1'b0,32'h0,      1'b0,1'b0,32'h0,      Z,  1'b1,1'b0,Z,   1'b0,1'b0,1'b0,1'b0,32'h0,     Z, 1'b0,1'b0,Z,  Z};
    vecs[20] = '{1'b0,1'b0,32'h0,      1'b0,1'b0,32'h0,      Z,  1'b1,1'b1,A5,  1'b0,1'b0,1'b0,1'b0,32'h0,     Z, 1'b0,1'b0,Z,  Z};
    vecs[21] = '{1'b0,1'b0,32'h0,      1'b0,1'b0,32'h0,      Z,  1'b1,1'b0,Z,   1'b0,1'b0,1'b0,1'b0,32'h0,     Z, 1'b0,1'b0,Z,  Z};

    // directed table: drive a cycle of inputs, then check outputs just after the edge
    for (int i = 0; i < 22; i++) begin
      rst_i = vecs[i].rst; bb_istek_i = vecs[i].bb_i; bb_adres_i = vecs[i].bb_adr;
      vb_istek_i = vecs[i].vb_i; vb_yaz_i = vecs[i].vb_yaz; vb_adres_i = vecs[i].vb_adr;
      vb_veri_i = vecs[i].vb_dat; ab_musait_i = vecs[i].musait; ab_bitti_i = vecs[i].bitti;
      ab_veri_i = vecs[i].ab_dat;
      @(posedge clk_i); #1;
      chk($sformatf("v%0d.bb_kabul", i), bb_kabul_o, vecs[i].e_bbk);
      chk($sformatf("v%0d.vb_kabul", i), vb_kabul_o, vecs[i].e_vbk);
      chk($sformatf("v%0d.ab_istek", i), ab_istek_o, vecs[i].e_ist);
      chk($sformatf("v%0d.ab_yaz", i), ab_yaz_o, vecs[i].e_yaz);
      chk($sformatf("v%0d.ab_adres", i), ab_adres_o, vecs[i].e_adr);
      chk($sformatf("v%0d.ab_veri", i), ab_veri_o, vecs[i].e_abdat);
      chk($sformatf("v%0d.bb_hazir", i), bb_hazir_o, vecs[i].e_bbh);
      chk($sformatf("v%0d.vb_hazir", i), vb_hazir_o, vecs[i].e_vbh);
      chk($sformatf("v%0d.bb_veri", i), bb_veri_o, vecs[i].e_bbdat);
      chk($sformatf("v%0d.vb_veri", i), vb_veri_o, vecs[i].e_vbdat);
    end

    // fairness: both requesters always active, engine finishes one cycle after each start
    begin
      int ng;
      int cyc;
      bit got[10];
      reset_dut();
      bb_istek_i = 1'b1; bb_adres_i = 32'h100; vb_istek_i = 1'b1; vb_adres_i = 32'h200;
      ng = 0; cyc = 0;
      while (ng < 10 && cyc < 200) begin
        @(posedge clk_i); #1;
        cyc++;
        ab_bitti_i = ab_istek_o;
        if (bb_kabul_o || vb_kabul_o) begin
          chk($sformatf("aclik.onehot%0d", ng), {bb_kabul_o, vb_kabul_o}, 2'b01 << bb_kabul_o);
          got[ng] = bb_kabul_o;
          ng++;
        end
      end
      chk("aclik.grant_count", ng, 10);
      for (int k = 0; k < ng; k++)
        chk($sformatf("aclik.grant%0d_is_instr", k), got[k], GUARD && (k % 5 == 4));
    end

    // randomized traffic against the reference model
    reset_dut();
    m_busy = 1'b0; m_kind = 1'b0; m_yaz = 1'b0; m_adr = 32'h0; m_abveri = Z;
    m_vbveri = Z; m_bbveri = Z; m_cnt = 0;
    bb_act = 1'b0; vb_act = 1'b0; eng_busy = 1'b0; eng_lat = 0;
    for (int c = 0; c < 400; c++) begin
      // predict this edge from the inputs currently driven
      p_vbk = !m_busy && ab_musait_i && vb_istek_i && !(bb_istek_i && GUARD && m_cnt >= ESIK);
      p_bbk = !m_busy && ab_musait_i && bb_istek_i && !p_vbk;
      p_vbh = m_busy && ab_bitti_i && !m_kind;
      p_bbh = m_busy && ab_bitti_i && m_kind;
      if (p_vbh && !m_yaz) m_vbveri = ab_veri_i;
      if (p_bbh) m_bbveri = ab_veri_i;
      if (p_vbh || p_bbh) m_busy = 1'b0;
      if (!bb_istek_i || p_bbk) m_cnt = 0;
      else if (p_vbk && m_cnt < ESIK) m_cnt++;
      if (p_vbk) begin
        m_busy = 1'b1; m_kind = 1'b0; m_adr = {vb_adres_i[31:4], 4'h0};
        m_yaz = vb_yaz_i; m_abveri = vb_veri_i;
      end else if (p_bbk) begin
        m_busy = 1'b1; m_kind = 1'b1; m_adr = {bb_adres_i[31:4], 4'h0}; m_yaz = 1'b0;
      end
      @(posedge clk_i); #1;
      chk($sformatf("r%0d.vb_kabul", c), vb_kabul_o, p_vbk);
      chk($sformatf("r%0d.bb_kabul", c), bb_kabul_o, p_bbk);
      chk($sformatf("r%0d.ab_istek", c), ab_istek_o, p_vbk | p_bbk);
      chk($sformatf("r%0d.vb_hazir", c), vb_hazir_o, p_vbh);
      chk($sformatf("r%0d.bb_hazir", c), bb_hazir_o, p_bbh);
      chk($sformatf("r%0d.ab_adres", c), ab_adres_o, m_adr);
      chk($sformatf("r%0d.ab_yaz", c), ab_yaz_o, m_yaz);
      chk($sformatf("r%0d.ab_veri", c), ab_veri_o, m_abveri);
      chk($sformatf("r%0d.vb_veri", c), vb_veri_o, m_vbveri);
      chk($sformatf("r%0d.bb_veri", c), bb_veri_o, m_bbveri);
      // requesters: hold until accepted, occasionally withdraw
      if (vb_kabul_o) vb_act = 1'b0;
      if (bb_kabul_o) bb_act = 1'b0;
      if (!vb_act) begin
        if ($urandom_range(0, 2) == 0) begin
          vb_act = 1'b1; vb_yaz_i = 1'($urandom_range(0, 1)); vb_adres_i = $urandom;
          vb_veri_i = {$urandom, $urandom, $urandom, $urandom};
        end
      end else if ($urandom_range(0, 15) == 0) begin
        vb_act = 1'b0;
      end
      if (!bb_act) begin
        if ($urandom_range(0, 2) == 0) begin
          bb_act = 1'b1; bb_adres_i = $urandom;
        end
      end else if ($urandom_range(0, 15) == 0) begin
        bb_act = 1'b0;
      end
      vb_istek_i = vb_act;
      bb_istek_i = bb_act;
      // burst engine: random latency, random read data
      if (ab_istek_o) begin
        eng_busy = 1'b1; eng_lat = $urandom_range(0, 3);
      end
      ab_bitti_i = 1'b0;
      ab_veri_i = {$urandom, $urandom, $urandom, $urandom};
      if (eng_busy) begin
        if (eng_lat == 0) begin
          ab_bitti_i = 1'b1; eng_busy = 1'b0;
        end else begin
          eng_lat--;
        end
      end
      ab_musait_i = !eng_busy && ($urandom_range(0, 7) != 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
